// File: rtl/npc_pkg.sv
// Shared definitions for the F-stage PC generator: address map constants and
// the next-PC source encoding.
package npc_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_PC    = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] IMEM_TOP  = 32'h0000_6FFF;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_BR,
    NPC_J,
    NPC_JR,
    NPC_EXC,
    NPC_ERET
  } npc_sel_t;

  // Any source other than sequential/hold counts as a redirect.
  function automatic logic is_redirect(npc_sel_t sel);
    return !(sel == NPC_SEQ || sel == NPC_HOLD);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: D-stage/CP0 redirect inputs toward the PC generator and the
// fetch PC status returned to the pipeline.
interface pc_fetch_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);

  logic             stall;
  logic             br_taken;
  logic             j_en;
  logic             jr_en;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] sign_imm;
  logic [25:0]      instr_index;
  logic [WIDTH-1:0] jr_target;
  logic             exc_req;
  logic             eret_req;
  logic [WIDTH-1:0] epc;

  logic [WIDTH-1:0] pc_f;
  logic [WIDTH-1:0] pc4_f;
  logic [WIDTH-1:0] npc;
  logic             flush_d;
  logic             fetch_adel;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output stall, br_taken, j_en, jr_en, pc_d, sign_imm, instr_index,
           jr_target, exc_req, eret_req, epc,
    input  pc_f, pc4_f, npc, flush_d, fetch_adel, redirect_cnt
  );

  modport slave (
    input  stall, br_taken, j_en, jr_en, pc_d, sign_imm, instr_index,
           jr_target, exc_req, eret_req, epc,
    output pc_f, pc4_f, npc, flush_d, fetch_adel, redirect_cnt
  );

endinterface

// File: rtl/npc_select.sv
// Combinational next-PC priority encoder and target mux.
// Priority: exc > eret > stall > br > j > jr > sequential.
module npc_select
  import npc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_f_i,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic             j_en_i,
  input  logic             jr_en_i,
  input  logic [WIDTH-1:0] pc_d_i,
  input  logic [WIDTH-1:0] sign_imm_i,
  input  logic [25:0]      instr_index_i,
  input  logic [WIDTH-1:0] jr_target_i,
  input  logic             exc_req_i,
  input  logic             eret_req_i,
  input  logic [WIDTH-1:0] epc_i,
  output npc_sel_t         sel_o,
  output logic [WIDTH-1:0] npc_o
);

  localparam logic [WIDTH-1:0] EXC_V = WIDTH'(EXC_PC);

  logic [WIDTH-1:0] pc4_d;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;

  assign pc4_d  = pc_d_i + WIDTH'(4);
  assign br_tgt = pc4_d + (sign_imm_i << 2);
  assign j_tgt  = {pc4_d[WIDTH-1:28], instr_index_i, 2'b00};

  always_comb begin
    sel_o = NPC_SEQ;
    if (exc_req_i)       sel_o = NPC_EXC;
    else if (eret_req_i) sel_o = NPC_ERET;
    else if (stall_i)    sel_o = NPC_HOLD;
    else if (br_taken_i) sel_o = NPC_BR;
    else if (j_en_i)     sel_o = NPC_J;
    else if (jr_en_i)    sel_o = NPC_JR;
  end

  always_comb begin
    npc_o = pc_f_i + WIDTH'(4);
    case (sel_o)
      NPC_EXC:  npc_o = EXC_V;
      NPC_ERET: npc_o = epc_i;
      NPC_HOLD: npc_o = pc_f_i;
      NPC_BR:   npc_o = br_tgt;
      NPC_J:    npc_o = j_tgt;
      NPC_JR:   npc_o = jr_target_i;
      default:  npc_o = pc_f_i + WIDTH'(4);
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// F-stage fetch PC register with next-PC selection, fetch address-error flag
// and a saturating count of non-sequential PC updates.
module pc_fetch_unit
  import npc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] BASE_V  = WIDTH'(IMEM_BASE);
  localparam logic [WIDTH-1:0] TOP_V   = WIDTH'(IMEM_TOP);
  localparam bit               DS_EN   = (DELAY_SLOT != 0);

  npc_sel_t         sel;
  logic [WIDTH-1:0] sel_npc;

  logic [WIDTH-1:0] pc_f_q, npc_d;
  logic             adel_q, adel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  npc_select #(.WIDTH(WIDTH)) u_npc_select (
    .pc_f_i        (pc_f_q),
    .stall_i       (bus.stall),
    .br_taken_i    (bus.br_taken),
    .j_en_i        (bus.j_en),
    .jr_en_i       (bus.jr_en),
    .pc_d_i        (bus.pc_d),
    .sign_imm_i    (bus.sign_imm),
    .instr_index_i (bus.instr_index),
    .jr_target_i   (bus.jr_target),
    .exc_req_i     (bus.exc_req),
    .eret_req_i    (bus.eret_req),
    .epc_i         (bus.epc),
    .sel_o         (sel),
    .npc_o         (sel_npc)
  );

  // npc must already show the reset vector while reset is held.
  assign npc_d  = reset ? RESET_V : sel_npc;
  assign adel_d = (npc_d[1:0] != 2'b00) || (npc_d < BASE_V) || (npc_d > TOP_V);
  assign cnt_d  = (is_redirect(sel) && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q <= RESET_V;
      adel_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pc_f_q <= npc_d;
      adel_q <= adel_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.pc_f         = pc_f_q;
  assign bus.pc4_f        = pc_f_q + WIDTH'(4);
  assign bus.npc          = npc_d;
  assign bus.fetch_adel   = adel_q;
  assign bus.redirect_cnt = cnt_q;
  assign bus.flush_d      = !reset && (bus.exc_req || bus.eret_req ||
                            (!DS_EN && !bus.stall &&
                             (bus.br_taken || bus.j_en || bus.jr_en)));

endmodule
